dm_port_arbiter: RTL and testbench
==================================

# dm_port_arbiter

Shares the single data-memory port between the CPU MEM stage and a DMA/loader requester. The CPU owns the port by default. A DMA request is latched into a one-entry holding register and issued when the CPU is idle, or forcibly after `MAX_WAIT` cycles, in which case the CPU is stalled for exactly one cycle. The block sits between the MEM-stage pipeline register and the data memory, and drives the memory's address, write-data, write-enable, width, sign and PC-tag inputs.

## Interface
- `MAX_WAIT`, 4: DMA starvation limit in cycles (1..15).
- `DMA_PC`, 32'h0000_0000: value driven on `dm_wpc` during DMA writes.
- `Clk` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `cpu_req` in 1: MEM stage has a load or store this cycle.
- `cpu_addr` in 32, `cpu_wd` in 32, `cpu_we` in 1, `cpu_width` in 2, `cpu_signed` in 1, `cpu_pc` in 32: CPU access fields. Width encoding: 00 word, 01 half, 10 byte.
- `cpu_stall` out 1: CPU access not performed this cycle; hold the MEM stage.
- `cpu_rd` out 32: load data, valid when `cpu_req && !cpu_stall`.
- `dma_req` in 1, `dma_ready` out 1: request handshake.
- `dma_addr` in 32, `dma_wd` in 32, `dma_we` in 1, `dma_width` in 2, `dma_signed` in 1: DMA fields, sampled at acceptance.
- `dma_done` out 1: one-cycle pulse, access completed.
- `dma_err` out 1: one-cycle pulse, access rejected.
- `dma_rd` out 32: registered load result.
- `dm_addr` out 32, `dm_wd` out 32, `dm_memwrite` out 1, `dm_opwidth` out 2, `dm_loadsigned` out 1, `dm_wpc` out 32: to the data memory.
- `dm_rd` in 32: combinational read data from the data memory.

## Operation
- States are IDLE and PEND. `dma_ready = (state == IDLE)`.
- **IDLE**
  - `dma_req && dma_ready` at the edge latches all DMA fields into the holding register, clears `wait_cnt`, and moves to PEND.
  - A latched access is rejected if it is misaligned: word with `addr[1:0] != 0`, half with `addr[0] != 0`, or width 11.
  - A rejected access does not enter PEND. It stays in IDLE, pulses `dma_err` next cycle, and never reaches memory.
- **PEND**
  - `dma_grant = !cpu_req || wait_cnt == MAX_WAIT`.
  - When `dma_grant` is high, the port is muxed to the holding register and `dm_wpc = DMA_PC`. At the edge:
    - the DM write commits;
    - `dma_rd <= dm_rd` for loads; stores leave `dma_rd` unchanged;
    - `dma_done` pulses next cycle;
    - the state returns to IDLE.
  - When `dma_grant` is low, `wait_cnt` increments and saturates at `MAX_WAIT`.
- **Port mux when DMA is not granted:** CPU fields pass through, with `dm_memwrite = cpu_req && cpu_we`.
- `cpu_stall = (state == PEND) && dma_grant && cpu_req`.
- `cpu_rd = dm_rd`, unconditionally.
- CPU misalignment is not checked here; it is handled in the pipeline.
- `dm_memwrite` is forced to 0 while `Reset` is high.
- **Reset:**
  - state IDLE, `wait_cnt = 0`, `dma_done = 0`, `dma_err = 0`, `dma_rd = 0`;
  - combinationally this gives `dma_ready = 1` and `cpu_stall = 0`.
- **Reset during PEND:** the pending DMA access is dropped. No `dma_done` and no memory write occur.

## Timing
- DMA latency from acceptance to `dma_done`, with the CPU idle: accept at edge N, issue in cycle N+1, `dma_done` high in cycle N+2.
- Worst case with the CPU continuously busy: `dma_done` arrives `MAX_WAIT + 2` cycles after acceptance.
- `dma_ready` is low from the cycle after acceptance through the issue cycle. It is high again in the `dma_done` cycle, so back-to-back DMA transfers are possible at one per 2 cycles.
- `cpu_stall` lasts at most one cycle per DMA access. The stalled CPU access is performed in the following cycle, because state is IDLE by then.
- Acceptance and issue never overlap, so the holding register is never overwritten while PEND.
- `dma_done` and `dma_err` are never high in the same cycle.

## Test plan
- **Idle CPU:** DMA store word `addr=0x10`, `wd=0xDEADBEEF`.
  - DM write in cycle N+1 with `dm_wpc = 0`, and `dma_done` in cycle N+2.
  - A following CPU `lw 0x10` returns 0xDEADBEEF.
- **Busy CPU, `MAX_WAIT = 4`:** CPU issues a load every cycle; DMA load byte signed at `0x13`, with memory word `0x80xxxxxx`.
  - The DMA waits 4 cycles and `cpu_stall` is high for exactly 1 cycle.
  - `dma_rd = 0xFFFFFF80`.
- **DMA during CPU gap:** DMA store half `addr=0x22`, `wd=0x1234`, while the CPU has a 1-cycle gap in its requests.
  - The DMA issues in the gap with no `cpu_stall`.
  - Word `0x20` upper half reads 0x1234.
- **Misaligned DMA:** DMA word at `0x6`.
  - `dma_err` pulses once, `dma_ready` never drops, and there is no DM write.
- **Reset while PEND with the CPU busy:** assert `Reset` for 1 cycle.
  - No `dma_done`, memory unchanged, and `dma_ready = 1` the cycle after Reset.
- **Back-to-back DMA:** two DMA stores to `0x0` and `0x4` with the CPU idle.
  - The second is accepted in the first's `dma_done` cycle and completes 2 cycles later.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage owns the port by default, and a
// one-entry DMA holding register steals a cycle when the CPU is idle or starved.
module dm_port_arbiter #(
  parameter int          MAX_WAIT = 4,
  parameter logic [31:0] DMA_PC   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_pc,
  output logic        cpu_stall,
  output logic [31:0] cpu_rd,
  input  logic        dma_req,
  output logic        dma_ready,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  input  logic        dma_we,
  input  logic [1:0]  dma_width,
  input  logic        dma_signed,
  output logic        dma_done,
  output logic        dma_err,
  output logic [31:0] dma_rd,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_memwrite,
  output logic [1:0]  dm_opwidth,
  output logic        dm_loadsigned,
  output logic [31:0] dm_wpc,
  input  logic [31:0] dm_rd
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] h_addr;
  logic [31:0] h_wd;
  logic        h_we;
  logic [1:0]  h_width;
  logic        h_signed;
  logic        dma_bad;
  logic        dma_grant;
  logic        dma_accept;

  always_comb begin
    dma_bad = 1'b0;
    unique case (dma_width)
      2'b00:   dma_bad = |dma_addr[1:0];
      2'b01:   dma_bad = dma_addr[0];
      2'b10:   dma_bad = 1'b0;
      default: dma_bad = 1'b1;
    endcase
  end

  assign dma_ready  = (state == IDLE);
  assign dma_accept = dma_req && dma_ready;
  assign dma_grant  = (state == PEND) &&
                      (!cpu_req || wait_cnt == MAXW);
  assign cpu_stall  = dma_grant && cpu_req;
  assign cpu_rd     = dm_rd;

  always_comb begin
    if (dma_grant) begin
      dm_addr       = h_addr;
      dm_wd         = h_wd;
      dm_memwrite   = h_we;
      dm_opwidth    = h_width;
      dm_loadsigned = h_signed;
      dm_wpc        = DMA_PC;
    end else begin
      dm_addr       = cpu_addr;
      dm_wd         = cpu_wd;
      dm_memwrite   = cpu_req && cpu_we;
      dm_opwidth    = cpu_width;
      dm_loadsigned = cpu_signed;
      dm_wpc        = cpu_pc;
    end
    if (Reset)
      dm_memwrite = 1'b0;
  end

  // Holding register loads only in IDLE, so it is stable for the whole PEND
  always_ff @(posedge Clk) begin
    if (dma_accept && !dma_bad) begin
      h_addr   <= dma_addr;
      h_wd     <= dma_wd;
      h_we     <= dma_we;
      h_width  <= dma_width;
      h_signed <= dma_signed;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      dma_done <= 1'b0;
      dma_err  <= 1'b0;
      dma_rd   <= 32'd0;
    end else begin
      dma_done <= 1'b0;
      dma_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dma_accept) begin
            if (dma_bad) begin
              dma_err <= 1'b1;
            end else begin
              state    <= PEND;
              wait_cnt <= 4'd0;
            end
          end
        end
        PEND: begin
          if (dma_grant) begin
            if (!h_we)
              dma_rd <= dm_rd;
            dma_done <= 1'b1;
            state    <= IDLE;
          end else if (wait_cnt != MAXW) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a little-endian
// data memory model behind the port.
module tb_dm_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic        cpu_we;
  logic [1:0]  cpu_width;
  logic        cpu_signed;
  logic [31:0] cpu_pc;
  logic        cpu_stall;
  logic [31:0] cpu_rd;
  logic        dma_req;
  logic        dma_ready;
  logic [31:0] dma_addr;
  logic [31:0] dma_wd;
  logic        dma_we;
  logic [1:0]  dma_width;
  logic        dma_signed;
  logic        dma_done;
  logic        dma_err;
  logic [31:0] dma_rd;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        dm_memwrite;
  logic [1:0]  dm_opwidth;
  logic        dm_loadsigned;
  logic [31:0] dm_wpc;
  logic [31:0] dm_rd;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wc;

  logic [31:0] mem [0:63] = '{default: 32'd0};
  logic [31:0] rw;
  logic [31:0] sh;

  always #5 Clk = ~Clk;

  dm_port_arbiter #(.MAX_WAIT(4), .DMA_PC(32'h0)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_we(cpu_we), .cpu_width(cpu_width), .cpu_signed(cpu_signed),
    .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .cpu_rd(cpu_rd),
    .dma_req(dma_req), .dma_ready(dma_ready), .dma_addr(dma_addr),
    .dma_wd(dma_wd), .dma_we(dma_we), .dma_width(dma_width),
    .dma_signed(dma_signed), .dma_done(dma_done), .dma_err(dma_err),
    .dma_rd(dma_rd), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .dm_memwrite(dm_memwrite), .dm_opwidth(dm_opwidth),
    .dm_loadsigned(dm_loadsigned), .dm_wpc(dm_wpc), .dm_rd(dm_rd)
  );

  always_comb begin
    rw = mem[dm_addr[7:2]];
    sh = rw >> (8 * dm_addr[1:0]);
    case (dm_opwidth)
      2'b01:   dm_rd = dm_loadsigned ? {{16{sh[15]}}, sh[15:0]}
                                     : {16'd0, sh[15:0]};
      2'b10:   dm_rd = dm_loadsigned ? {{24{sh[7]}}, sh[7:0]}
                                     : {24'd0, sh[7:0]};
      default: dm_rd = rw;
    endcase
  end

  always @(posedge Clk) begin
    if (dm_memwrite) begin
      wr_cnt <= wr_cnt + 1;
      case (dm_opwidth)
        2'b01:   mem[dm_addr[7:2]][16*dm_addr[1] +: 16] <= dm_wd[15:0];
        2'b10:   mem[dm_addr[7:2]][8*dm_addr[1:0] +: 8] <= dm_wd[7:0];
        default: mem[dm_addr[7:2]] <= dm_wd;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cpu(input logic rq, input logic [31:0] a,
                     input logic we, input logic [31:0] wd);
    cpu_req   = rq;
    cpu_addr  = a;
    cpu_we    = we;
    cpu_wd    = wd;
    cpu_width = 2'b00;
  endtask

  task automatic dma(input logic [31:0] a, input logic [31:0] wd,
                     input logic we, input logic [1:0] w,
                     input logic s);
    dma_req    = 1'b1;
    dma_addr   = a;
    dma_wd     = wd;
    dma_we     = we;
    dma_width  = w;
    dma_signed = s;
  endtask

  initial begin
    Reset = 1'b1;
    cpu(1'b0, 32'h0, 1'b0, 32'h0);
    cpu_signed = 1'b0;
    cpu_pc     = 32'h0000_0100;
    dma_req    = 1'b0;
    dma_addr   = 32'h0;
    dma_wd     = 32'h0;
    dma_we     = 1'b0;
    dma_width  = 2'b00;
    dma_signed = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_ready", dma_ready, 1);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_err", dma_err, 0);
    chk("rst_rd", dma_rd, 0);
    Reset = 1'b0;

    // idle CPU: DMA store word
    dma(32'h10, 32'hDEAD_BEEF, 1'b1, 2'b00, 1'b0);
    settle();
    chk("t1_ready_pre", dma_ready, 1);
    tick();
    dma_req = 1'b0;
    settle();
    chk("t1_ready_iss", dma_ready, 0);
    chk("t1_we", dm_memwrite, 1);
    chk("t1_addr", dm_addr, 32'h10);
    chk("t1_wd", dm_wd, 32'hDEAD_BEEF);
    chk("t1_wpc", dm_wpc, 32'h0);
    chk("t1_stall", cpu_stall, 0);
    tick();
    chk("t1_done", dma_done, 1);
    chk("t1_ready_done", dma_ready, 1);
    cpu(1'b1, 32'h10, 1'b0, 32'h0);
    settle();
    chk("t1_lw", cpu_rd, 32'hDEAD_BEEF);
    chk("t1_cpu_wpc", dm_wpc, 32'h100);
    tick();
    chk("t1_done_pulse", dma_done, 0);

    // busy CPU: DMA signed byte load forced after MAX_WAIT
    cpu(1'b1, 32'h10, 1'b1, 32'h8011_2233);
    settle();
    chk("t2_cpu_sw", dm_memwrite, 1);
    tick();
    cpu(1'b1, 32'h40, 1'b0, 32'h0);
    dma(32'h13, 32'h0, 1'b0, 2'b10, 1'b1);
    tick();
    dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_wait_stall%0d", i), cpu_stall, 0);
      chk($sformatf("t2_wait_addr%0d", i), dm_addr, 32'h40);
      chk($sformatf("t2_wait_ready%0d", i), dma_ready, 0);
      tick();
    end
    settle();
    chk("t2_stall", cpu_stall, 1);
    chk("t2_addr", dm_addr, 32'h13);
    chk("t2_width", dm_opwidth, 2'b10);
    chk("t2_sign", dm_loadsigned, 1);
    chk("t2_nowrite", dm_memwrite, 0);
    tick();
    chk("t2_done", dma_done, 1);
    chk("t2_rd", dma_rd, 32'hFFFF_FF80);
    chk("t2_stall_once", cpu_stall, 0);
    chk("t2_cpu_addr", dm_addr, 32'h40);
    tick();

    // DMA store half issued in a CPU gap
    dma(32'h22, 32'h0000_1234, 1'b1, 2'b01, 1'b0);
    tick();
    dma_req = 1'b0;
    cpu_req = 1'b0;
    settle();
    chk("t3_we", dm_memwrite, 1);
    chk("t3_addr", dm_addr, 32'h22);
    chk("t3_width", dm_opwidth, 2'b01);
    chk("t3_stall", cpu_stall, 0);
    tick();
    cpu(1'b1, 32'h20, 1'b0, 32'h0);
    settle();
    chk("t3_done", dma_done, 1);
    chk("t3_stall2", cpu_stall, 0);
    chk("t3_lw", cpu_rd, 32'h1234_0000);
    tick();

    // misaligned DMA word, then reserved width
    cpu_req = 1'b0;
    wc = wr_cnt;
    dma(32'h6, 32'h5555_5555, 1'b1, 2'b00, 1'b0);
    tick();
    dma_req = 1'b0;
    settle();
    chk("t4_err", dma_err, 1);
    chk("t4_ready", dma_ready, 1);
    chk("t4_done", dma_done, 0);
    chk("t4_nowrite", dm_memwrite, 0);
    tick();
    chk("t4_err_pulse", dma_err, 0);
    chk("t4_ready2", dma_ready, 1);
    dma(32'h8, 32'h6666_6666, 1'b1, 2'b11, 1'b0);
    tick();
    dma_req = 1'b0;
    chk("t4_err_w11", dma_err, 1);
    tick();
    chk("t4_wrcnt", wr_cnt, wc);

    // reset while PEND, CPU busy
    cpu(1'b1, 32'h30, 1'b0, 32'h0);
    dma(32'h30, 32'hCAFE_F00D, 1'b1, 2'b00, 1'b0);
    tick();
    dma_req = 1'b0;
    chk("t5_pend", dma_ready, 0);
    Reset = 1'b1;
    cpu(1'b1, 32'h30, 1'b1, 32'h0000_0BAD);
    settle();
    chk("t5_rst_nowrite", dm_memwrite, 0);
    tick();
    Reset = 1'b0;
    cpu(1'b1, 32'h30, 1'b0, 32'h0);
    settle();
    chk("t5_ready", dma_ready, 1);
    chk("t5_done", dma_done, 0);
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("t5_nodone%0d", i), dma_done, 0);
      chk($sformatf("t5_nostall%0d", i), cpu_stall, 0);
      tick();
    end
    chk("t5_mem", cpu_rd, 32'h0);

    // back-to-back DMA stores, CPU idle
    cpu_req = 1'b0;
    dma(32'h0, 32'h1111_1111, 1'b1, 2'b00, 1'b0);
    tick();
    dma(32'h4, 32'h2222_2222, 1'b1, 2'b00, 1'b0);
    settle();
    chk("t6_ready1", dma_ready, 0);
    chk("t6_addr1", dm_addr, 32'h0);
    chk("t6_wd1", dm_wd, 32'h1111_1111);
    tick();
    chk("t6_done1", dma_done, 1);
    chk("t6_ready_acc", dma_ready, 1);
    tick();
    dma_req = 1'b0;
    settle();
    chk("t6_addr2", dm_addr, 32'h4);
    chk("t6_we2", dm_memwrite, 1);
    chk("t6_nodone", dma_done, 0);
    tick();
    chk("t6_done2", dma_done, 1);
    cpu(1'b1, 32'h0, 1'b0, 32'h0);
    settle();
    chk("t6_lw0", cpu_rd, 32'h1111_1111);
    cpu(1'b1, 32'h4, 1'b0, 32'h0);
    settle();
    chk("t6_lw4", cpu_rd, 32'h2222_2222);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
